ahb_sram_slave: RTL and testbench

AHB-Lite responder that terminates pipelined bus transfers into a single-port synchronous SRAM. It generates `o_hready_resp`, `o_hresp` and `o_hrdata` for the master side, so it is the far end of the bus pipeline stages in the subsystem. Writes complete with zero wait states. Reads insert a fixed number of wait states. Illegal transfers get a two-cycle ERROR response.

---
 rtl/ahb_slv_pkg.sv | 53 +++++
 rtl/ahb_slv_chk.sv | 22 ++
 rtl/ahb_sram_slave.sv | 151 +++++++++++++++
 tb/tb_ahb_sram_slave.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slv_pkg.sv
// Shared constants, FSM state encoding and the byte-enable decoder for the
// AHB-Lite SRAM responder.
package ahb_slv_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RWAIT,
        ST_CAP,
        ST_RESP,
        ST_ERR1,
        ST_ERR2
    } state_t;

    typedef struct packed {
        logic [3:0] be;
        logic       illegal;
    } be_dec_t;

    // Sizes above a word and misaligned half/word accesses are flagged illegal.
    function automatic be_dec_t be_decode(input logic [2:0] size, input logic [1:0] addr_lo);
        be_dec_t r;
        r.be      = 4'b0000;
        r.illegal = 1'b0;
        case (size)
            HSIZE_BYTE: r.be = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                r.be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                r.illegal = addr_lo[0];
            end
            HSIZE_WORD: begin
                r.be      = 4'b1111;
                r.illegal = (addr_lo != 2'b00);
            end
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ahb_slv_chk.sv
// Address-phase legality check: window range, transfer size and alignment,
// together with the byte-enable pattern for the accepted transfer.
module ahb_slv_chk
    import ahb_slv_pkg::*;
#(
    parameter int ADDR_WID = 21,
    parameter int MEM_AW   = 12
) (
    input  logic [ADDR_WID-1:MEM_AW+2] addr_hi,
    input  logic [1:0]                 addr_lo,
    input  logic [2:0]                 hsize,
    output logic [3:0]                 be,
    output logic                       illegal
);

    be_dec_t dec;

    assign dec     = be_decode(hsize, addr_lo);
    assign be      = dec.be;
    assign illegal = dec.illegal | (|addr_hi);

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a single-port synchronous SRAM: zero-wait
// writes, fixed-latency reads and a two-cycle ERROR response.
module ahb_sram_slave
    import ahb_slv_pkg::*;
#(
    parameter int ADDR_WID = 21,
    parameter int MEM_AW   = 12,
    parameter int RD_WAIT  = 0
) (
    input  logic                hclk,
    input  logic                hrstn,
    input  logic                i_hsel,
    input  logic                i_hready,
    input  logic [ADDR_WID-1:0] i_haddr,
    input  logic [1:0]          i_htrans,
    input  logic                i_hwrite,
    input  logic [2:0]          i_hsize,
    input  logic [31:0]         i_hwdata,
    output logic                o_hready_resp,
    output logic [1:0]          o_hresp,
    output logic [31:0]         o_hrdata,
    output logic                o_mem_cs,
    output logic                o_mem_we,
    output logic [MEM_AW-1:0]   o_mem_addr,
    output logic [3:0]          o_mem_be,
    output logic [31:0]         o_mem_wdata,
    input  logic [31:0]         i_mem_rdata
);

    localparam logic [1:0] WAIT_LAST = (RD_WAIT > 0) ? 2'(RD_WAIT - 1) : 2'd0;

    state_t              state;
    state_t              state_nxt;
    logic [MEM_AW-1:0]   addr_q;
    logic [3:0]          be_q;
    logic [1:0]          wait_cnt;
    logic [31:0]         hrdata_q;
    logic [3:0]          chk_be;
    logic                chk_illegal;
    logic                open;
    logic                htrans_active;
    logic                accept;

    ahb_slv_chk #(
        .ADDR_WID (ADDR_WID),
        .MEM_AW   (MEM_AW)
    ) u_chk (
        .addr_hi (i_haddr[ADDR_WID-1:MEM_AW+2]),
        .addr_lo (i_haddr[1:0]),
        .hsize   (i_hsize),
        .be      (chk_be),
        .illegal (chk_illegal)
    );

    assign open          = (state == ST_IDLE) || (state == ST_WR) ||
                           (state == ST_RESP) || (state == ST_ERR2);
    assign htrans_active = (i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ);
    assign accept        = open & i_hsel & i_hready & htrans_active;

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        o_hready_resp = 1'b0;
        o_hresp       = HRESP_OKAY;
        o_mem_cs      = 1'b0;
        o_mem_we      = 1'b0;
        case (state)
            ST_IDLE, ST_WR, ST_RESP, ST_ERR2: begin
                o_hready_resp = 1'b1;
                if (state == ST_WR) begin
                    o_mem_cs = 1'b1;
                    o_mem_we = 1'b1;
                end
                if (state == ST_ERR2) begin
                    o_hresp = HRESP_ERROR;
                end
                if (!accept) begin
                    state_nxt = ST_IDLE;
                end else if (chk_illegal) begin
                    state_nxt = ST_ERR1;
                end else if (i_hwrite) begin
                    state_nxt = ST_WR;
                end else begin
                    state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                o_mem_cs  = 1'b1;
                state_nxt = (RD_WAIT > 0) ? ST_RWAIT : ST_CAP;
            end
            ST_RWAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_CAP;
                end
            end
            ST_CAP: begin
                state_nxt = ST_RESP;
            end
            ST_ERR1: begin
                o_hresp   = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address-phase fields are captured only on accept so they stay stable
    // through the whole data phase, including read wait states.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            addr_q <= '0;
            be_q   <= 4'b0000;
        end else if (accept) begin
            addr_q <= i_haddr[MEM_AW+1:2];
            be_q   <= chk_be;
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            wait_cnt <= 2'd0;
        end else if (state == ST_RD) begin
            wait_cnt <= 2'd0;
        end else if (state == ST_RWAIT) begin
            wait_cnt <= wait_cnt + 2'd1;
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            hrdata_q <= 32'h0;
        end else if (state == ST_CAP) begin
            hrdata_q <= i_mem_rdata;
        end
    end

    assign o_hrdata    = hrdata_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_be    = o_mem_cs ? be_q : 4'b0000;
    assign o_mem_wdata = o_mem_we ? i_hwdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: one instance with RD_WAIT=0 and one
// with RD_WAIT=3, each acting as the only slave on its bus.
module tb_ahb_sram_slave;
    import ahb_slv_pkg::*;

    typedef struct packed {
        logic        rd;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [7:0]  stall;
    } bus_exp_t;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    logic        hclk = 1'b0;
    logic        rst0, rst3;
    logic        sel;
    logic [20:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    logic        hsel0, hsel3;
    logic        rdy0, rdy3;
    logic [1:0]  resp0, resp3;
    logic [31:0] rdata0, rdata3;
    logic        cs0, cs3, we0, we3;
    logic [11:0] maddr0, maddr3;
    logic [3:0]  be0, be3;
    logic [31:0] wd0, wd3;
    logic [31:0] mrd0, mrd3;

    logic [31:0] mem0 [0:4095];
    logic [31:0] mem3 [0:4095];

    int checks = 0;
    int failures = 0;

    bus_exp_t bus_q[$];
    mem_exp_t mem_q[$];

    always #5 hclk = ~hclk;

    assign hsel0 = (sel == 1'b0);
    assign hsel3 = (sel == 1'b1);

    ahb_sram_slave #(.ADDR_WID(21), .MEM_AW(12), .RD_WAIT(0)) dut0 (
        .hclk(hclk), .hrstn(rst0), .i_hsel(hsel0), .i_hready(rdy0),
        .i_haddr(haddr), .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize),
        .i_hwdata(hwdata), .o_hready_resp(rdy0), .o_hresp(resp0), .o_hrdata(rdata0),
        .o_mem_cs(cs0), .o_mem_we(we0), .o_mem_addr(maddr0), .o_mem_be(be0),
        .o_mem_wdata(wd0), .i_mem_rdata(mrd0)
    );

    ahb_sram_slave #(.ADDR_WID(21), .MEM_AW(12), .RD_WAIT(3)) dut3 (
        .hclk(hclk), .hrstn(rst3), .i_hsel(hsel3), .i_hready(rdy3),
        .i_haddr(haddr), .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize),
        .i_hwdata(hwdata), .o_hready_resp(rdy3), .o_hresp(resp3), .o_hrdata(rdata3),
        .o_mem_cs(cs3), .o_mem_we(we3), .o_mem_addr(maddr3), .o_mem_be(be3),
        .o_mem_wdata(wd3), .i_mem_rdata(mrd3)
    );

    // SRAM behaviour: read data valid the cycle after cs, held until next cs.
    always @(posedge hclk) begin
        if (cs0) begin
            if (we0) begin
                for (int b = 0; b < 4; b++)
                    if (be0[b]) mem0[maddr0][8*b +: 8] <= wd0[8*b +: 8];
            end else begin
                mrd0 <= mem0[maddr0];
            end
        end
    end

    always @(posedge hclk) begin
        if (cs3) begin
            if (we3) begin
                for (int k = 0; k < 4; k++)
                    if (be3[k]) mem3[maddr3][8*k +: 8] <= wd3[8*k +: 8];
            end else begin
                mrd3 <= mem3[maddr3];
            end
        end
    end

    logic        cur_rstn, cur_hsel, cur_hready, cur_cs, cur_we;
    logic [1:0]  cur_hresp;
    logic [31:0] cur_rdata, cur_wdata;
    logic [11:0] cur_maddr;
    logic [3:0]  cur_be;

    assign cur_rstn   = sel ? rst3   : rst0;
    assign cur_hsel   = sel ? hsel3  : hsel0;
    assign cur_hready = sel ? rdy3   : rdy0;
    assign cur_hresp  = sel ? resp3  : resp0;
    assign cur_rdata  = sel ? rdata3 : rdata0;
    assign cur_cs     = sel ? cs3    : cs0;
    assign cur_we     = sel ? we3    : we0;
    assign cur_maddr  = sel ? maddr3 : maddr0;
    assign cur_be     = sel ? be3    : be0;
    assign cur_wdata  = sel ? wd3    : wd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Bus monitor: tracks data phases and pops one expectation per completion.
    logic       pending = 1'b0;
    int         stall = 0;
    logic       stall_bad = 1'b0;

    always @(negedge hclk) begin
        bus_exp_t e;
        if (!cur_rstn) begin
            pending   = 1'b0;
            stall     = 0;
            stall_bad = 1'b0;
        end else begin
            if (pending) begin
                if (cur_hready) begin
                    if (bus_q.size() == 0) begin
                        check("unexpected_completion", 32'h1, 32'h0);
                    end else begin
                        e = bus_q.pop_front();
                        check("hresp", {30'h0, cur_hresp}, {30'h0, e.resp});
                        check("wait_cycles", stall, {24'h0, e.stall});
                        check("stall_hresp", {31'h0, stall_bad}, 32'h0);
                        if (e.rd && e.resp == HRESP_OKAY) check("hrdata", cur_rdata, e.data);
                    end
                    pending = 1'b0;
                end else begin
                    stall++;
                    if (bus_q.size() > 0 && cur_hresp !== bus_q[0].resp) stall_bad = 1'b1;
                end
            end
            if (cur_hsel && htrans[1] && cur_hready) begin
                pending   = 1'b1;
                stall     = 0;
                stall_bad = 1'b0;
            end
        end
    end

    // SRAM port monitor: every cs must match a queued access.
    always @(negedge hclk) begin
        mem_exp_t m;
        if (cur_cs) begin
            if (mem_q.size() == 0) begin
                check("unexpected_cs", {20'h0, cur_maddr}, 32'hFFFF_FFFF);
            end else begin
                m = mem_q.pop_front();
                check("mem_we", {31'h0, cur_we}, {31'h0, m.we});
                check("mem_addr", {20'h0, cur_maddr}, {20'h0, m.addr});
                check("mem_be", {28'h0, cur_be}, {28'h0, m.be});
                if (m.we) check("mem_wdata", cur_wdata, m.wdata);
            end
        end
    end

    task automatic xfer(input logic wr, input logic [2:0] sz, input logic [20:0] a,
                        input logic [31:0] wd, input logic [1:0] eresp,
                        input logic [31:0] erdata, input logic [3:0] ebe);
        bus_exp_t be_;
        mem_exp_t me;
        logic     acc;
        int       waitc;
        be_.rd    = !wr;
        be_.resp  = eresp;
        be_.data  = erdata;
        be_.stall = (eresp == HRESP_ERROR) ? 8'd1 : (wr ? 8'd0 : (sel ? 8'd5 : 8'd2));
        bus_q.push_back(be_);
        if (eresp == HRESP_OKAY) begin
            me.we    = wr;
            me.addr  = a[13:2];
            me.be    = ebe;
            me.wdata = wd;
            mem_q.push_back(me);
        end
        haddr  = a;
        htrans = HTRANS_NONSEQ;
        hwrite = wr;
        hsize  = sz;
        acc    = 1'b0;
        waitc  = 0;
        while (!acc && waitc < 20) begin
            @(negedge hclk);
            acc = cur_hready;
            @(posedge hclk);
            #1;
            waitc++;
        end
        if (!acc) check("accept_timeout", 32'h0, 32'h1);
        hwdata = wd;
    endtask

    task automatic idle(input int n);
        htrans = HTRANS_IDLE;
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hready"}, {31'h0, cur_hready}, 32'h1);
        check({tag, "_hresp"},  {30'h0, cur_hresp}, 32'h0);
        check({tag, "_hrdata"}, cur_rdata, 32'h0);
        check({tag, "_cs"},     {31'h0, cur_cs}, 32'h0);
        check({tag, "_we"},     {31'h0, cur_we}, 32'h0);
        check({tag, "_be"},     {28'h0, cur_be}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sel    = 1'b0;
        rst0   = 1'b0;
        rst3   = 1'b0;
        haddr  = '0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        hwdata = 32'h0;
        #3;
        check_reset_values("reset0");
        repeat (2) @(posedge hclk);
        #1;
        rst0 = 1'b1;
        rst3 = 1'b1;
        idle(2);

        // RD_WAIT = 0 instance
        xfer(1, HSIZE_WORD, 21'h10, 32'hDEADBEEF, HRESP_OKAY, 32'h0, 4'b1111);
        xfer(0, HSIZE_WORD, 21'h10, 32'h0, HRESP_OKAY, 32'hDEADBEEF, 4'b1111);
        idle(4);
        xfer(1, HSIZE_WORD, 21'h0, 32'h11111111, HRESP_OKAY, 32'h0, 4'b1111);
        xfer(1, HSIZE_WORD, 21'h4, 32'h22222222, HRESP_OKAY, 32'h0, 4'b1111);
        xfer(1, HSIZE_WORD, 21'h8, 32'h33333333, HRESP_OKAY, 32'h0, 4'b1111);
        xfer(0, HSIZE_WORD, 21'h4, 32'h0, HRESP_OKAY, 32'h22222222, 4'b1111);
        idle(4);
        xfer(1, HSIZE_BYTE, 21'h13, 32'hAB000000, HRESP_OKAY, 32'h0, 4'b1000);
        xfer(1, HSIZE_HALF, 21'h12, 32'h55660000, HRESP_OKAY, 32'h0, 4'b1100);
        xfer(1, HSIZE_HALF, 21'h11, 32'h0, HRESP_ERROR, 32'h0, 4'b0000);
        xfer(0, HSIZE_WORD, 21'h10, 32'h0, HRESP_OKAY, 32'h5566BEEF, 4'b1111);
        idle(4);
        xfer(1, HSIZE_WORD, 21'h4010, 32'h0, HRESP_ERROR, 32'h0, 4'b0000);
        xfer(0, 3'd3, 21'h0, 32'h0, HRESP_ERROR, 32'h0, 4'b0000);
        xfer(0, HSIZE_WORD, 21'h6, 32'h0, HRESP_ERROR, 32'h0, 4'b0000);
        xfer(1, HSIZE_WORD, 21'h40, 32'h0BADF00D, HRESP_OKAY, 32'h0, 4'b1111);
        xfer(0, HSIZE_WORD, 21'h40, 32'h0, HRESP_OKAY, 32'h0BADF00D, 4'b1111);
        xfer(1, HSIZE_BYTE, 21'h41, 32'h0000C300, HRESP_OKAY, 32'h0, 4'b0010);
        idle(4);

        htrans = HTRANS_IDLE;
        @(negedge hclk);
        check("idle_hready", {31'h0, cur_hready}, 32'h1);
        check("idle_hresp", {30'h0, cur_hresp}, 32'h0);
        check("idle_cs", {31'h0, cur_cs}, 32'h0);
        htrans = HTRANS_BUSY;
        @(posedge hclk);
        #1;
        @(negedge hclk);
        check("busy_hready", {31'h0, cur_hready}, 32'h1);
        check("busy_cs", {31'h0, cur_cs}, 32'h0);
        @(posedge hclk);
        #1;
        idle(2);

        // RD_WAIT = 3 instance, including reset during the wait states
        sel = 1'b1;
        idle(1);
        xfer(1, HSIZE_WORD, 21'h24, 32'hA5A55A5A, HRESP_OKAY, 32'h0, 4'b1111);
        xfer(0, HSIZE_WORD, 21'h24, 32'h0, HRESP_OKAY, 32'hA5A55A5A, 4'b1111);
        idle(8);
        xfer(0, HSIZE_WORD, 21'h24, 32'h0, HRESP_OKAY, 32'hA5A55A5A, 4'b1111);
        idle(1);
        check("rwait_hready", {31'h0, cur_hready}, 32'h0);
        rst3 = 1'b0;
        #1;
        check_reset_values("midread");
        void'(bus_q.pop_back());
        repeat (2) @(posedge hclk);
        #1;
        rst3 = 1'b1;
        idle(2);
        xfer(1, HSIZE_WORD, 21'h20, 32'hCAFEF00D, HRESP_OKAY, 32'h0, 4'b1111);
        xfer(0, HSIZE_WORD, 21'h20, 32'h0, HRESP_OKAY, 32'hCAFEF00D, 4'b1111);
        idle(10);

        check("bus_queue_empty", bus_q.size(), 32'h0);
        check("mem_queue_empty", mem_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
